alu_sequencer: RTL and testbench

- Runs multi-byte arithmetic and logic operations on the 8-bit ALU, one byte per clock, LSB first.
- Drives the ALU operand and operation inputs, captures each result byte, and reports the aggregated flags of the whole word.
- Sits between a requester (microcode sequencer or a wide-op unit) and the ALU's lhs_in/rhs_in/operation inputs.
- Byte 0 uses the requester's first-byte op (e.g. ADD/SUB); later bytes use the chained op (e.g. ADC/SBC), so the ALU's internal previous-carry propagates the carry between bytes.

---
 rtl/alu_sequencer_if.sv | 64 ++++++
 rtl/alu_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signals of the multi-byte ALU sequencer.
// slave is the sequencer's view; master is the requester/ALU/consumer view.
interface alu_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_BYTES = 4
);
    localparam int WORD = WIDTH * MAX_BYTES;
    localparam int CNTW = $clog2(MAX_BYTES + 1);

    logic             req_valid;
    logic             req_ready;
    logic [WORD-1:0]  req_lhs;
    logic [WORD-1:0]  req_rhs;
    logic [3:0]       req_op_first;
    logic [3:0]       req_op_next;
    logic [CNTW-1:0]  req_bytes;

    logic [WIDTH-1:0] alu_lhs;
    logic [WIDTH-1:0] alu_rhs;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] alu_result;
    logic             alu_flag_zero;
    logic             alu_flag_acarry;
    logic             alu_flag_lcarry;
    logic             alu_flag_sign;
    logic             alu_flag_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WORD-1:0]  rsp_result;
    logic             rsp_zero;
    logic             rsp_acarry;
    logic             rsp_lcarry;
    logic             rsp_sign;
    logic             rsp_overflow;

    logic             busy;

    modport slave (
        input  req_valid, req_lhs, req_rhs,
        input  req_op_first, req_op_next, req_bytes,
        output req_ready,
        output alu_lhs, alu_rhs, alu_operation,
        input  alu_result, alu_flag_zero, alu_flag_acarry,
        input  alu_flag_lcarry, alu_flag_sign, alu_flag_overflow,
        output rsp_valid, rsp_result, rsp_zero, rsp_acarry,
        output rsp_lcarry, rsp_sign, rsp_overflow,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req_valid, req_lhs, req_rhs,
        output req_op_first, req_op_next, req_bytes,
        input  req_ready,
        input  alu_lhs, alu_rhs, alu_operation,
        output alu_result, alu_flag_zero, alu_flag_acarry,
        output alu_flag_lcarry, alu_flag_sign, alu_flag_overflow,
        input  rsp_valid, rsp_result, rsp_zero, rsp_acarry,
        input  rsp_lcarry, rsp_sign, rsp_overflow,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Feeds a wide operation through the 8-bit ALU one byte per clock, LSB first,
// assembling the result word and the flags of the whole word.
module alu_sequencer #(
    parameter int         WIDTH     = 8,
    parameter int         MAX_BYTES = 4,
    parameter logic [3:0] IDLE_OP   = 4'h0
) (
    input logic            clk,
    input logic            reset_n,
    alu_sequencer_if.slave bus
);
    localparam int WORD = WIDTH * MAX_BYTES;
    localparam int CNTW = $clog2(MAX_BYTES + 1);
    localparam int IDXW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] last_eff;
    logic [WORD-1:0] lhs_q;
    logic [WORD-1:0] rhs_q;
    logic [WORD-1:0] result_q;
    logic [3:0]      op_first_q;
    logic [3:0]      op_next_q;
    logic            zero_acc;
    logic            acarry_q;
    logic            lcarry_q;
    logic            sign_q;
    logic            overflow_q;
    logic            accept;
    logic            step;
    logic            at_last;

    // Zero or oversize byte counts mean a full-width word.
    always_comb begin
        if (bus.req_bytes == '0 || bus.req_bytes > CNTW'(MAX_BYTES))
            last_eff = IDXW'(MAX_BYTES - 1);
        else
            last_eff = IDXW'(bus.req_bytes - CNTW'(1));
    end

    assign accept  = (state == S_IDLE) && bus.req_valid;
    assign step    = (state == S_RUN);
    assign at_last = (idx == last_idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx          = state;
        bus.req_ready     = 1'b0;
        bus.busy          = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.alu_lhs       = '0;
        bus.alu_rhs       = '0;
        bus.alu_operation = IDLE_OP;
        unique case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_nx = S_RUN;
            end
            S_RUN: begin
                bus.busy    = 1'b1;
                bus.alu_lhs = lhs_q[int'(idx)*WIDTH +: WIDTH];
                bus.alu_rhs = rhs_q[int'(idx)*WIDTH +: WIDTH];
                // Byte 0 starts the chain; later bytes consume the ALU carry.
                bus.alu_operation = (idx == '0) ? op_first_q : op_next_q;
                if (at_last)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            last_idx   <= '0;
            lhs_q      <= '0;
            rhs_q      <= '0;
            result_q   <= '0;
            op_first_q <= IDLE_OP;
            op_next_q  <= IDLE_OP;
            zero_acc   <= 1'b0;
            acarry_q   <= 1'b0;
            lcarry_q   <= 1'b0;
            sign_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            idx        <= '0;
            last_idx   <= last_eff;
            lhs_q      <= bus.req_lhs;
            rhs_q      <= bus.req_rhs;
            result_q   <= '0;
            op_first_q <= bus.req_op_first;
            op_next_q  <= bus.req_op_next;
            zero_acc   <= 1'b1;
            acarry_q   <= 1'b0;
            lcarry_q   <= 1'b0;
            sign_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (step) begin
            result_q[int'(idx)*WIDTH +: WIDTH] <= bus.alu_result;
            zero_acc <= zero_acc & bus.alu_flag_zero;
            if (at_last) begin
                acarry_q   <= bus.alu_flag_acarry;
                lcarry_q   <= bus.alu_flag_lcarry;
                sign_q     <= bus.alu_flag_sign;
                overflow_q <= bus.alu_flag_overflow;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    assign bus.rsp_result   = result_q;
    assign bus.rsp_zero     = zero_acc;
    assign bus.rsp_acarry   = acarry_q;
    assign bus.rsp_lcarry   = lcarry_q;
    assign bus.rsp_sign     = sign_q;
    assign bus.rsp_overflow = overflow_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: an 8-bit ALU model, a word-level reference model
// checked every cycle, directed literal cases and randomized traffic.
module tb_alu_sequencer;
    localparam logic [3:0] IDLE = 4'h0;
    localparam logic [3:0] ADD  = 4'h1;
    localparam logic [3:0] ADC  = 4'h2;
    localparam logic [3:0] SUB  = 4'h3;
    localparam logic [3:0] SBC  = 4'h4;
    localparam logic [3:0] AND_ = 4'h5;
    localparam logic [3:0] OR_  = 4'h6;
    localparam logic [3:0] XOR_ = 4'h7;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 0;

    alu_sequencer_if #(.WIDTH(8), .MAX_BYTES(4)) bus ();

    alu_sequencer #(
        .WIDTH(8),
        .MAX_BYTES(4),
        .IDLE_OP(IDLE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU byte model with a previous-carry register updated every clock
    logic pc = 1'b0;
    always_comb begin
        logic [8:0] t;
        logic [7:0] a;
        logic [7:0] b;
        logic ov;
        a = bus.alu_lhs;
        b = bus.alu_rhs;
        t = '0;
        ov = 1'b0;
        case (bus.alu_operation)
            ADD: begin
                t = {1'b0, a} + {1'b0, b};
                ov = (a[7] == b[7]) && (t[7] != a[7]);
            end
            ADC: begin
                t = {1'b0, a} + {1'b0, b} + {8'd0, pc};
                ov = (a[7] == b[7]) && (t[7] != a[7]);
            end
            SUB: begin
                t = {1'b0, a} - {1'b0, b};
                ov = (a[7] != b[7]) && (t[7] != a[7]);
            end
            SBC: begin
                t = {1'b0, a} - {1'b0, b} - {8'd0, pc};
                ov = (a[7] != b[7]) && (t[7] != a[7]);
            end
            AND_: t = {1'b0, a & b};
            OR_:  t = {1'b0, a | b};
            XOR_: t = {1'b0, a ^ b};
            default: t = '0;
        endcase
        bus.alu_result        = t[7:0];
        bus.alu_flag_zero     = (t[7:0] == 8'd0);
        bus.alu_flag_acarry   = t[8];
        bus.alu_flag_lcarry   = a[7];
        bus.alu_flag_sign     = t[7];
        bus.alu_flag_overflow = ov;
    end

    always @(posedge clk) pc <= bus.alu_flag_acarry;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: whole-word arithmetic on N bytes.
    typedef struct packed {
        logic [31:0] res;
        logic z;
        logic ac;
        logic lc;
        logic s;
        logic ov;
    } exp_t;

    function automatic int eff_n(input logic [2:0] nb);
        return (nb == 0 || nb > 4) ? 4 : int'(nb);
    endfunction

    function automatic exp_t word_model(input logic [31:0] l, input logic [31:0] r,
                                        input logic [3:0] op, input int n);
        exp_t e;
        int bits;
        logic [63:0] mask, a, b, full;
        bits = 8 * n;
        mask = (64'd1 << bits) - 64'd1;
        a = {32'd0, l} & mask;
        b = {32'd0, r} & mask;
        case (op)
            ADD:  full = a + b;
            SUB:  full = a - b;
            AND_: full = a & b;
            OR_:  full = a | b;
            XOR_: full = a ^ b;
            default: full = '0;
        endcase
        e = '0;
        e.res = 32'(full & mask);
        e.z = (e.res == 32'd0);
        e.lc = a[bits-1];
        e.s = e.res[bits-1];
        if (op == ADD) begin
            e.ac = full[bits];
            e.ov = (a[bits-1] == b[bits-1]) && (e.s != a[bits-1]);
        end else if (op == SUB) begin
            e.ac = (a < b);
            e.ov = (a[bits-1] != b[bits-1]) && (e.s != a[bits-1]);
        end
        return e;
    endfunction

    // Transaction-level model: 0 idle, 1 byte k in flight, 2 result held
    int m_phase, m_k, m_n;
    logic [31:0] m_lhs, m_rhs;
    logic [3:0] m_opf, m_opn;
    exp_t m_exp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0;
            m_k <= 0;
        end else begin
            case (m_phase)
                0: if (bus.req_valid) begin
                    m_lhs <= bus.req_lhs;
                    m_rhs <= bus.req_rhs;
                    m_opf <= bus.req_op_first;
                    m_opn <= bus.req_op_next;
                    m_n <= eff_n(bus.req_bytes);
                    m_exp <= word_model(bus.req_lhs, bus.req_rhs, bus.req_op_first,
                                        eff_n(bus.req_bytes));
                    m_k <= 0;
                    m_phase <= 1;
                end
                1: if (m_k == m_n - 1) m_phase <= 2;
                   else m_k <= m_k + 1;
                default: if (bus.rsp_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            chk("req_ready", bus.req_ready, m_phase == 0);
            chk("busy", bus.busy, m_phase == 1);
            chk("rsp_valid", bus.rsp_valid, m_phase == 2);
            if (m_phase == 1) begin
                chk("alu_lhs", bus.alu_lhs, m_lhs[8*m_k +: 8]);
                chk("alu_rhs", bus.alu_rhs, m_rhs[8*m_k +: 8]);
                chk("alu_op", bus.alu_operation, (m_k == 0) ? m_opf : m_opn);
            end else begin
                chk("alu_lhs_idle", bus.alu_lhs, 0);
                chk("alu_rhs_idle", bus.alu_rhs, 0);
                chk("alu_op_idle", bus.alu_operation, IDLE);
            end
            if (m_phase == 2) begin
                chk("rsp_result", bus.rsp_result, m_exp.res);
                chk("rsp_zero", bus.rsp_zero, m_exp.z);
                chk("rsp_acarry", bus.rsp_acarry, m_exp.ac);
                chk("rsp_lcarry", bus.rsp_lcarry, m_exp.lc);
                chk("rsp_sign", bus.rsp_sign, m_exp.s);
                chk("rsp_overflow", bus.rsp_overflow, m_exp.ov);
            end
        end
    end

    logic [3:0] ops_seen[8];
    int nops;

    task automatic set_req(input logic [31:0] l, input logic [31:0] r,
                           input logic [3:0] of, input logic [3:0] on,
                           input logic [2:0] nb);
        bus.req_lhs = l;
        bus.req_rhs = r;
        bus.req_op_first = of;
        bus.req_op_next = on;
        bus.req_bytes = nb;
        bus.req_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r,
                        input logic [3:0] of, input logic [3:0] on,
                        input logic [2:0] nb, output int lat);
        int waited;
        bit ok;
        set_req(l, r, of, on, nb);
        ok = 0;
        waited = 0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            waited++;
            ok = bus.req_ready;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
        lat = 0;
        nops = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (nops < 8) begin
                ops_seen[nops] = bus.alu_operation;
                nops++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] held;
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_lhs = '0;
        bus.req_rhs = '0;
        bus.req_op_first = IDLE;
        bus.req_op_next = IDLE;
        bus.req_bytes = '0;
        bus.rsp_ready = 1'b0;
        #3;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_flags", {bus.rsp_zero, bus.rsp_acarry, bus.rsp_lcarry,
                          bus.rsp_sign, bus.rsp_overflow}, 0);
        chk("rst_alu", {bus.alu_lhs, bus.alu_rhs, bus.alu_operation}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1;
        @(posedge clk);
        #1;

        send(32'h0000_00FF, 32'h0000_0001, ADD, ADC, 3'd2, lat);
        chk("add16_latency", lat, 2);
        chk("add16_result", bus.rsp_result, 32'h0000_0100);
        chk("add16_flags", {bus.rsp_zero, bus.rsp_acarry, bus.rsp_sign,
                            bus.rsp_overflow}, 4'b0000);
        take_rsp();

        send(32'h0000_FFFF, 32'h0000_0001, ADD, ADC, 3'd2, lat);
        chk("wrap_result", bus.rsp_result, 32'h0);
        chk("wrap_zero", bus.rsp_zero, 1);
        chk("wrap_acarry", bus.rsp_acarry, 1);
        take_rsp();

        send(32'h0000_7FFF, 32'h0000_0001, ADD, ADC, 3'd2, lat);
        chk("ovf_result", bus.rsp_result, 32'h0000_8000);
        chk("ovf_flags", {bus.rsp_zero, bus.rsp_sign, bus.rsp_overflow}, 3'b011);
        take_rsp();

        send(32'h0, 32'h1, SUB, SBC, 3'd0, lat);
        chk("sub32_latency", lat, 4);
        chk("sub32_result", bus.rsp_result, 32'hFFFF_FFFF);
        chk("sub32_sz", {bus.rsp_sign, bus.rsp_zero}, 2'b10);
        chk("sub32_nops", nops, 4);
        chk("sub32_op0", ops_seen[0], SUB);
        for (int k = 1; k < 4; k++) chk("sub32_opk", ops_seen[k], SBC);
        take_rsp();

        send(32'hABCD_EF12, 32'h0000_0034, ADD, ADC, 3'd1, lat);
        chk("n1_latency", lat, 1);
        chk("n1_result", bus.rsp_result, 32'h0000_0046);
        take_rsp();

        send(32'h5500_0001, 32'h55FF_FFFF, ADD, ADC, 3'd3, lat);
        chk("n3_result", bus.rsp_result, 32'h0);
        chk("n3_zc", {bus.rsp_zero, bus.rsp_acarry}, 2'b11);
        take_rsp();

        // backpressure with a competing request pending
        send(32'h0000_1234, 32'h0000_0101, ADD, ADC, 3'd2, lat);
        held = bus.rsp_result;
        chk("bp_result", held, 32'h0000_1335);
        set_req(32'h05, 32'h03, AND_, AND_, 3'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_hold", bus.rsp_result, held);
            chk("bp_ready", bus.req_ready, 0);
        end
        @(posedge clk);
        #1;
        take_rsp();
        @(negedge clk);
        chk("bp_idle_ready", bus.req_ready, 1);
        chk("bp_idle_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_accept", bus.busy, 1);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_new_result", bus.rsp_result, 32'h01);
        take_rsp();

        // reset in the second RUN cycle of a 4-byte op
        set_req(32'h1122_3344, 32'h0101_0101, ADD, ADC, 3'd4);
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mr_valid", bus.rsp_valid, 0);
        chk("mr_result", bus.rsp_result, 0);
        chk("mr_op", bus.alu_operation, IDLE);
        chk("mr_ready", bus.req_ready, 1);
        chk("mr_busy", bus.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'hF0, 32'h3C, AND_, AND_, 3'd1, lat);
        chk("and_result", bus.rsp_result, 32'h30);
        chk("and_zero", bus.rsp_zero, 0);
        take_rsp();

        for (int i = 0; i < 2500; i++) begin
            logic [3:0] of;
            logic [3:0] on;
            case ($urandom_range(0, 4))
                0: begin of = ADD; on = ADC; end
                1: begin of = SUB; on = SBC; end
                2: begin of = AND_; on = AND_; end
                3: begin of = OR_; on = OR_; end
                default: begin of = XOR_; on = XOR_; end
            endcase
            bus.req_valid = ($urandom_range(0, 2) != 0);
            bus.req_lhs = $urandom;
            bus.req_rhs = $urandom;
            bus.req_op_first = of;
            bus.req_op_next = on;
            bus.req_bytes = 3'($urandom_range(0, 7));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
